// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
package mem_arb_pkg;

    // Default widths and fairness limit
    localparam int DEF_AW        = 32;
    localparam int DEF_DW        = 32;
    localparam int DEF_MAX_D_RUN = 4;

    // MemRW bit positions: [1] = read, [0] = write (2'b11 counts as a read)
    localparam int MEMRW_RD = 1;
    localparam int MEMRW_WR = 0;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side and bus-side signals of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the environment
// (IF/MEM stages plus the memory slave).
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    // Instruction fetch side
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              iready_n;
    logic [DW-1:0]     i_rdata;

    // Data access side
    logic              d_req;
    logic [1:0]        d_rw;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              dready_n;
    logic [DW-1:0]     d_rdata;
    logic              dbusy;

    // External memory bus
    logic              bus_req;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW/8-1:0]   bus_be;
    logic              bus_ack;
    logic [DW-1:0]     bus_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, d_be,
               bus_ack, bus_rdata,
        output iready_n, i_rdata, dready_n, d_rdata, dbusy,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport master (
        output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, d_be,
               bus_ack, bus_rdata,
        input  iready_n, i_rdata, dready_n, d_rdata, dbusy,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

endinterface

// File: rtl/mem_bus_arbiter_wbuf.sv
// One-entry posted write buffer: holds a single accepted store until the
// arbiter drains it onto the bus.
module mem_wbuf
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [AW-1:0]   w_addr,
    input  logic [DW-1:0]   w_data,
    input  logic [DW/8-1:0] w_be,
    output logic            valid,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   data,
    output logic [DW/8-1:0] be
);

    // Capture a store on load, release the entry on clear (never both at once)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            be    <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end
            if (load) begin
                valid <= 1'b1;
                addr  <= w_addr;
                data  <= w_data;
                be    <= w_be;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch and data access.
// Data side has priority; a run counter forces a fetch after MAX_D_RUN data
// grants so IF always makes progress. Stores are posted through mem_wbuf.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_D_RUN = DEF_MAX_D_RUN
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus_if
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_I_RD = I_RD;
    localparam logic [1:0] ST_D_RD = D_RD;
    localparam logic [1:0] ST_D_WR = D_WR;
    localparam int         CW      = $clog2(MAX_D_RUN + 1);

    logic [1:0]      state;
    logic [1:0]      grant;
    logic [CW-1:0]   dcnt;
    logic            dcnt_max;

    logic            bus_req_r;
    logic            bus_we_r;
    logic [AW-1:0]   bus_addr_r;
    logic [DW-1:0]   bus_wdata_r;
    logic [DW/8-1:0] bus_be_r;

    logic            iready_n_r;
    logic            dready_n_r;
    logic [DW-1:0]   i_rdata_r;
    logic [DW-1:0]   d_rdata_r;

    logic            d_rd_pend;
    logic            st_req;
    logic            st_accept;
    logic            wb_clear;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [DW/8-1:0] wb_be;

    assign d_rd_pend = bus_if.d_req && bus_if.d_rw[MEMRW_RD];
    assign st_req    = bus_if.d_req && bus_if.d_rw[MEMRW_WR] && !bus_if.d_rw[MEMRW_RD];
    assign st_accept = st_req && !wb_valid;
    assign wb_clear  = (state == ST_D_WR) && bus_if.bus_ack;
    assign dcnt_max  = (dcnt == CW'(MAX_D_RUN));

    assign bus_if.dbusy     = st_req && wb_valid;
    assign bus_if.bus_req   = bus_req_r;
    assign bus_if.bus_we    = bus_we_r;
    assign bus_if.bus_addr  = bus_addr_r;
    assign bus_if.bus_wdata = bus_wdata_r;
    assign bus_if.bus_be    = bus_be_r;
    assign bus_if.iready_n  = iready_n_r;
    assign bus_if.dready_n  = dready_n_r;
    assign bus_if.i_rdata   = i_rdata_r;
    assign bus_if.d_rdata   = d_rdata_r;

    mem_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk    (clk),
        .rst    (rst),
        .load   (st_accept),
        .clear  (wb_clear),
        .w_addr (bus_if.d_addr),
        .w_data (bus_if.d_wdata),
        .w_be   (bus_if.d_be),
        .valid  (wb_valid),
        .addr   (wb_addr),
        .data   (wb_data),
        .be     (wb_be)
    );

    // Pick the next transaction; pending writes drain before a load so a
    // load never overtakes an older store to the same address
    always_comb begin
        grant = ST_IDLE;
        if (bus_if.i_req && dcnt_max) begin
            grant = ST_I_RD;
        end else if (d_rd_pend && wb_valid) begin
            grant = ST_D_WR;
        end else if (d_rd_pend) begin
            grant = ST_D_RD;
        end else if (bus_if.i_req) begin
            grant = ST_I_RD;
        end else if (wb_valid) begin
            grant = ST_D_WR;
        end
    end

    // FSM and registered bus outputs, loaded on leaving IDLE and held until ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            bus_be_r    <= '0;
        end else if (state == ST_IDLE) begin
            state <= grant;
            case (grant)
                ST_I_RD: begin
                    bus_req_r   <= 1'b1;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= bus_if.i_addr;
                    bus_wdata_r <= '0;
                    bus_be_r    <= '1;
                end
                ST_D_RD: begin
                    bus_req_r   <= 1'b1;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= bus_if.d_addr;
                    bus_wdata_r <= '0;
                    bus_be_r    <= '1;
                end
                ST_D_WR: begin
                    bus_req_r   <= 1'b1;
                    bus_we_r    <= 1'b1;
                    bus_addr_r  <= wb_addr;
                    bus_wdata_r <= wb_data;
                    bus_be_r    <= wb_be;
                end
                default: begin
                    bus_req_r <= 1'b0;
                end
            endcase
        end else if (bus_if.bus_ack) begin
            state     <= ST_IDLE;
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
        end
    end

    // Deliver read data for one cycle, but only if the requester still wants
    // the same address (a flushed or redirected request drops the data)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iready_n_r <= 1'b1;
            dready_n_r <= 1'b1;
            i_rdata_r  <= '0;
            d_rdata_r  <= '0;
        end else begin
            iready_n_r <= 1'b1;
            dready_n_r <= 1'b1;
            if (state == ST_I_RD && bus_if.bus_ack && bus_if.i_req &&
                bus_if.i_addr == bus_addr_r) begin
                i_rdata_r  <= bus_if.bus_rdata;
                iready_n_r <= 1'b0;
            end
            if (state == ST_D_RD && bus_if.bus_ack && d_rd_pend &&
                bus_if.d_addr == bus_addr_r) begin
                d_rdata_r  <= bus_if.bus_rdata;
                dready_n_r <= 1'b0;
            end
        end
    end

    // Count consecutive data grants made while a fetch is waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
        end else if (state == ST_IDLE) begin
            if (!bus_if.i_req || grant == ST_I_RD) begin
                dcnt <= '0;
            end else if ((grant == ST_D_RD || grant == ST_D_WR) && !dcnt_max) begin
                dcnt <= dcnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small memory slave model whose
// ack latency is programmable.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bif ();

    mem_bus_arbiter #(
        .AW        (32),
        .DW        (32),
        .MAX_D_RUN (4)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .bus_if (bif)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int ack_delay    = 0;
    int busy_cycles  = 0;

    logic [31:0] dmem [0:255];

    // Instruction ROM contents below 0x200
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h100: rom_word = 32'h2402000A;
            32'h104: rom_word = 32'h8C430000;
            32'h108: rom_word = 32'h00851020;
            default: rom_word = 32'h00000013;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Slave: ack after ack_delay wait cycles, write data lands at the ack edge
    assign bif.bus_ack = bif.bus_req && (busy_cycles >= ack_delay);

    always @(posedge clk) begin
        if (bif.bus_req && !bif.bus_ack) busy_cycles <= busy_cycles + 1;
        else                             busy_cycles <= 0;
        if (bif.bus_req && bif.bus_ack && bif.bus_we)
            dmem[bif.bus_addr[9:2]] <= merge(dmem[bif.bus_addr[9:2]], bif.bus_wdata, bif.bus_be);
    end

    always_comb begin
        if (bif.bus_addr >= 32'h200) bif.bus_rdata = dmem[bif.bus_addr[9:2]];
        else                         bif.bus_rdata = rom_word(bif.bus_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watchdog so a stuck DUT cannot hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int  d_grants;
        bit  fetch_seen;
        bit  done;
        bit  reissued;
        logic [2:0] dcnt_at;

        rst_n       = 1'b0;
        bif.i_req   = 1'b0;
        bif.i_addr  = '0;
        bif.d_req   = 1'b0;
        bif.d_rw    = 2'b00;
        bif.d_addr  = '0;
        bif.d_wdata = '0;
        bif.d_be    = '0;
        ack_delay   = 0;

        // Reset values
        #12;
        check("rst_bus_req",  bif.bus_req,  1'b0);
        check("rst_bus_we",   bif.bus_we,   1'b0);
        check("rst_bus_addr", bif.bus_addr, 32'h0);
        check("rst_iready_n", bif.iready_n, 1'b1);
        check("rst_dready_n", bif.dready_n, 1'b1);
        check("rst_dbusy",    bif.dbusy,    1'b0);
        check("rst_i_rdata",  bif.i_rdata,  32'h0);
        check("rst_d_rdata",  bif.d_rdata,  32'h0);
        #5 rst_n = 1'b1;
        tick();

        // Zero-wait fetch from 0x100
        $display("[TB] zero-wait fetch");
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h100;
        tick();
        check("f1_bus_req",  bif.bus_req,  1'b1);
        check("f1_bus_we",   bif.bus_we,   1'b0);
        check("f1_bus_addr", bif.bus_addr, 32'h100);
        check("f1_iready_busy", bif.iready_n, 1'b1);
        tick();
        check("f1_iready_n", bif.iready_n, 1'b0);
        check("f1_i_rdata",  bif.i_rdata,  32'h2402000A);
        check("f1_bus_idle", bif.bus_req,  1'b0);
        bif.i_req = 1'b0;
        tick();
        check("f1_iready_pulse", bif.iready_n, 1'b1);

        // Posted store, then load of the same address while a fetch waits
        $display("[TB] posted store then load");
        bif.d_req   = 1'b1;
        bif.d_rw    = 2'b01;
        bif.d_addr  = 32'h200;
        bif.d_wdata = 32'hDEADBEEF;
        bif.d_be    = 4'hF;
        #1;
        check("st_dbusy", bif.dbusy, 1'b0);
        tick();
        bif.d_rw    = 2'b10;
        bif.d_wdata = '0;
        bif.i_req   = 1'b1;
        bif.i_addr  = 32'h104;
        tick();
        check("sl_wr_req",   bif.bus_req,   1'b1);
        check("sl_wr_we",    bif.bus_we,    1'b1);
        check("sl_wr_addr",  bif.bus_addr,  32'h200);
        check("sl_wr_wdata", bif.bus_wdata, 32'hDEADBEEF);
        check("sl_wr_be",    bif.bus_be,    4'hF);
        tick();
        check("sl_gap_req", bif.bus_req, 1'b0);
        tick();
        check("sl_rd_req",  bif.bus_req,  1'b1);
        check("sl_rd_we",   bif.bus_we,   1'b0);
        check("sl_rd_addr", bif.bus_addr, 32'h200);
        tick();
        check("sl_dready_n", bif.dready_n, 1'b0);
        check("sl_d_rdata",  bif.d_rdata,  32'hDEADBEEF);
        check("sl_iready_wait", bif.iready_n, 1'b1);
        bif.d_req = 1'b0;
        bif.d_rw  = 2'b00;
        tick();
        check("sl_fetch_addr", bif.bus_addr, 32'h104);
        check("sl_fetch_req",  bif.bus_req,  1'b1);
        tick();
        check("sl_iready_n", bif.iready_n, 1'b0);
        check("sl_i_rdata",  bif.i_rdata,  32'h8C430000);
        bif.i_req = 1'b0;
        tick();

        // Full buffer with a slow slave
        $display("[TB] full write buffer");
        ack_delay   = 3;
        bif.d_req   = 1'b1;
        bif.d_rw    = 2'b01;
        bif.d_addr  = 32'h200;
        bif.d_wdata = 32'h11112222;
        bif.d_be    = 4'hF;
        #1;
        check("fb_first_dbusy", bif.dbusy, 1'b0);
        tick();
        bif.d_addr  = 32'h204;
        bif.d_wdata = 32'h33334444;
        bif.d_be    = 4'h3;
        #1;
        check("fb_dbusy_s1", bif.dbusy, 1'b1);
        tick();
        check("fb_drain_addr", bif.bus_addr, 32'h200);
        check("fb_dbusy_s2",   bif.dbusy,    1'b1);
        tick();
        check("fb_dbusy_s3", bif.dbusy, 1'b1);
        tick();
        check("fb_dbusy_s4", bif.dbusy, 1'b1);
        tick();
        check("fb_dbusy_ack",  bif.dbusy,   1'b1);
        check("fb_req_at_ack", bif.bus_req, 1'b1);
        tick();
        check("fb_dbusy_free", bif.dbusy,   1'b0);
        check("fb_bus_idle",   bif.bus_req, 1'b0);
        tick();
        bif.d_req = 1'b0;
        bif.d_rw  = 2'b00;
        tick();
        check("fb_second_req",   bif.bus_req,   1'b1);
        check("fb_second_we",    bif.bus_we,    1'b1);
        check("fb_second_addr",  bif.bus_addr,  32'h204);
        check("fb_second_wdata", bif.bus_wdata, 32'h33334444);
        check("fb_second_be",    bif.bus_be,    4'h3);
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            tick();
            if (!bif.bus_req) done = 1'b1;
        end
        check("fb_drain_done", done, 1'b1);
        ack_delay = 0;
        tick();

        // Anti-starvation: loads back to back with a fetch waiting
        $display("[TB] fetch starvation guard");
        d_grants    = 0;
        fetch_seen  = 1'b0;
        dcnt_at     = 3'h7;
        bif.i_req   = 1'b1;
        bif.i_addr  = 32'h108;
        bif.d_req   = 1'b1;
        bif.d_rw    = 2'b10;
        bif.d_addr  = 32'h200;
        for (int c = 0; c < 40 && !fetch_seen; c++) begin
            tick();
            if (bif.dready_n == 1'b0)
                bif.d_addr = (bif.d_addr == 32'h200) ? 32'h204 : 32'h200;
            if (bif.bus_req && !bif.bus_we && bif.bus_addr == 32'h108) begin
                fetch_seen = 1'b1;
                dcnt_at    = 3'(dut.dcnt);
            end else if (bif.bus_req && bif.bus_ack) begin
                d_grants++;
            end
        end
        check("sv_fetch_granted", fetch_seen, 1'b1);
        check("sv_data_grants",   d_grants,   4);
        check("sv_dcnt_cleared",  dcnt_at,    3'h0);
        bif.d_req = 1'b0;
        bif.d_rw  = 2'b00;
        tick();
        check("sv_iready_n", bif.iready_n, 1'b0);
        check("sv_i_rdata",  bif.i_rdata,  32'h00851020);
        bif.i_req = 1'b0;
        tick();

        // Fetch flushed while in flight
        $display("[TB] fetch flush");
        ack_delay  = 2;
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h10C;
        tick();
        check("fl_bus_req",  bif.bus_req,  1'b1);
        check("fl_bus_addr", bif.bus_addr, 32'h10C);
        bif.i_req = 1'b0;
        tick();
        tick();
        check("fl_ack_cycle_req", bif.bus_req, 1'b1);
        tick();
        check("fl_done_req",  bif.bus_req,  1'b0);
        check("fl_iready_n",  bif.iready_n, 1'b1);
        tick();
        check("fl_iready_n2", bif.iready_n, 1'b1);
        check("fl_idle_req",  bif.bus_req,  1'b0);

        // Asynchronous reset in the middle of a buffered write
        $display("[TB] reset during write drain");
        ack_delay   = 3;
        bif.d_req   = 1'b1;
        bif.d_rw    = 2'b01;
        bif.d_addr  = 32'h300;
        bif.d_wdata = 32'h55AA55AA;
        bif.d_be    = 4'hF;
        tick();
        bif.d_req = 1'b0;
        bif.d_rw  = 2'b00;
        tick();
        check("ar_pre_req",  bif.bus_req,  1'b1);
        check("ar_pre_we",   bif.bus_we,   1'b1);
        check("ar_pre_addr", bif.bus_addr, 32'h300);
        #3 rst_n = 1'b0;
        #1;
        check("ar_bus_req",  bif.bus_req,  1'b0);
        check("ar_bus_we",   bif.bus_we,   1'b0);
        check("ar_wb_valid", dut.wb_valid, 1'b0);
        check("ar_iready_n", bif.iready_n, 1'b1);
        check("ar_dready_n", bif.dready_n, 1'b1);
        check("ar_dbusy",    bif.dbusy,    1'b0);
        #2 rst_n = 1'b1;
        reissued = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bif.bus_req) reissued = 1'b1;
        end
        check("ar_no_reissue", reissued, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
